// File: rtl/ha_serial_seq.sv
// ha_serial_seq
//
// Bit-serial adder sequencer. A single one-bit adder slice (two half-adder
// cells plus a carry flop) is stepped LSB-first across the operands. Each
// result is op_a + op_b + cin, returned as WIDTH+1 bits.
//
// Ports:
//   i_clk    system clock, rising edge
//   i_rst    asynchronous active-high reset
//   i_start  request, sampled only in IDLE
//   i_abort  cancels a RUN; also blocks i_start in IDLE
//   i_op_a   operand A, captured on start acceptance
//   i_op_b   operand B, captured on start acceptance
//   i_cin    carry-in, captured on start acceptance
//   o_busy   high while in RUN
//   o_done   one-cycle pulse while in DONE
//   o_sum    registered {carry_out, sum bits}; holds between operations
module ha_serial_seq #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic             i_abort,
    input  logic [WIDTH-1:0] i_op_a,
    input  logic [WIDTH-1:0] i_op_b,
    input  logic             i_cin,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH:0]   o_sum
);

    // WIDTH is at most 8, so a 4-bit step counter always suffices.
    localparam int unsigned CntW = 4;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_carry;
    logic [CntW-1:0]  r_cnt;
    logic [WIDTH-1:0] r_part;
    logic [WIDTH:0]   r_sum;

    logic             w_p;
    logic             w_g;
    logic             w_s;
    logic             w_g2;
    logic             w_carry_nxt;
    logic [WIDTH-1:0] w_part_nxt;
    logic             w_last;

    // Half adder 1 on the current operand LSBs.
    assign w_p = r_a[0] ^ r_b[0];
    assign w_g = r_a[0] & r_b[0];

    // Half adder 2 folds in the running carry.
    assign w_s  = w_p ^ r_carry;
    assign w_g2 = w_p & r_carry;

    assign w_carry_nxt = w_g | w_g2;

    // Sum bits enter at the MSB so the first (LSB) bit ends up at bit 0
    // after WIDTH steps. Written this way so WIDTH=1 needs no special case.
    always_comb begin
        w_part_nxt             = r_part >> 1;
        w_part_nxt[WIDTH-1]    = w_s;
    end

    assign w_last = (r_cnt == CntW'(WIDTH - 1));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= StIdle;
            r_a     <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_part  <= '0;
            r_sum   <= '0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (i_start && !i_abort) begin
                        r_a     <= i_op_a;
                        r_b     <= i_op_b;
                        r_carry <= i_cin;
                        r_cnt   <= '0;
                        r_part  <= '0;
                        r_state <= StRun;
                    end
                end
                StRun: begin
                    if (i_abort) begin
                        // Datapath left as-is; it is reloaded on next accept.
                        r_state <= StIdle;
                    end else begin
                        r_carry <= w_carry_nxt;
                        r_a     <= r_a >> 1;
                        r_b     <= r_b >> 1;
                        r_part  <= w_part_nxt;
                        r_cnt   <= r_cnt + CntW'(1);
                        if (w_last) begin
                            r_sum   <= {w_carry_nxt, w_part_nxt};
                            r_state <= StDone;
                        end
                    end
                end
                StDone: begin
                    r_state <= StIdle;
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign o_busy = (r_state == StRun);
    assign o_done = (r_state == StDone);
    assign o_sum  = r_sum;

endmodule

// File: doc/ha_serial_seq.md
# ha_serial_seq

Bit-serial addition sequencer that time-shares a single one-bit adder slice between all bit positions of two WIDTH-bit operands. The slice is built from two half-adder cells plus a carry flop. The block accepts an operand pair on a start strobe, steps the slice LSB-first for WIDTH cycles, and presents a registered WIDTH+1-bit sum with a one-cycle done pulse. It sits between the tile's input pins and output pins as the control layer over the half-adder datapath.

## Interface
- WIDTH, 4, operand width in bits; legal range 1..8.

- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- abort  in  1  cancels an in-progress operation.
- op_a  in  WIDTH  operand A; captured when start is accepted.
- op_b  in  WIDTH  operand B; captured when start is accepted.
- cin  in  1  carry-in; captured when start is accepted.
- busy  out  1  high while state is RUN.
- done  out  1  high for exactly one cycle, while state is DONE.
- sum  out  WIDTH+1  registered result {carry_out, sum bits}; holds between operations.

## Operation
- States: IDLE, RUN, DONE. Reset state is IDLE.
- IDLE:
  - If start=1 and abort=0: capture op_a into shift register A, op_b into B, and cin into the carry flop; clear the bit counter and the partial-result register; go to RUN.
  - Otherwise stay in IDLE.
- RUN, once per cycle:
  - Half adder 1: p = A[0]^B[0], g = A[0]&B[0].
  - Half adder 2: s = p^carry, g2 = p&carry.
  - carry <= g|g2.
  - Shift A and B right by one.
  - Shift s into the MSB of the partial result (right shift), so that after WIDTH steps the partial result holds bits [WIDTH-1:0].
  - Counter increments. When the counter equals WIDTH-1, this step is the last: load sum <= {carry_next, partial_next} and go to DONE.
- DONE: done=1, then return to IDLE unconditionally. A start seen in DONE is ignored; it is accepted only once the FSM is back in IDLE.
- abort=1 in RUN: go to IDLE on the next edge. sum is unchanged and no done pulse is produced. abort in IDLE or DONE has no effect, except that it blocks start in IDLE (abort wins).
- start in RUN or DONE is ignored. Operand or cin changes after acceptance have no effect on the result.
- Arithmetic: sum = op_a + op_b + cin, exact. The maximum value is 2^(WIDTH+1)-1, so the result never overflows.
- WIDTH=1: RUN lasts one cycle and the counter compare is trivially true.
- Reset (rst=1, asynchronous, at any time including mid-RUN):
  - state=IDLE, busy=0, done=0, sum=0.
  - A, B, carry, counter and partial result are all 0.
  - Takes effect without a clock edge. The FSM leaves IDLE only on an edge where rst=0.

## Timing
- Edge E0 accepts start. busy=1 from E0 through E_WIDTH.
- sum is updated and done=1 at edge E_WIDTH. done falls and the FSM is back in IDLE at E_WIDTH+1.
- Latency from start acceptance to done: WIDTH+1 edges to the done edge.
- With start held high, throughput is one result per WIDTH+2 cycles (6 cycles for WIDTH=4).
- busy and done are never high simultaneously. Both are Moore outputs decoded from state; there are no combinational paths from inputs to outputs.
- sum changes only at the RUN→DONE transition and on reset.

## Test plan
- Reset: assert rst with the clock stopped → busy=0, done=0, sum=0 immediately. Release rst → state remains IDLE, outputs remain 0.
- WIDTH=4, op_a=4'hF, op_b=4'h1, cin=0, pulse start → busy high for 4 cycles, done pulse at E4, sum=5'h10. done is low at E5.
- op_a=4'hF, op_b=4'hF, cin=1 → sum=5'h1F.
- op_a=4'h0, op_b=4'h0, cin=1 → sum=5'h01.
- Hold start high with op_a=3, op_b=4, and change the operands to 9/9 during RUN:
  - The first result is sum=5'h07.
  - done pulses every 6 cycles.
  - The next result uses operands captured at the next acceptance (9+9 → 5'h12).
- Mid-operation interrupts:
  - Assert abort at the second RUN cycle → busy low at the next edge, no done pulse, sum retains its prior value.
  - Assert abort together with start in IDLE → FSM stays in IDLE.
  - Assert rst asynchronously mid-RUN → all outputs go to 0 immediately. A start after release completes normally.
